// File: rtl/sysarr_pkg.sv
// Shared definitions for the systolic-array memory sequencers (mem_read, mem_write):
// the sequencer FSM state encoding and the bank depth / address width helpers.
package sysarr_pkg;

    // state    | meaning
    // ST_IDLE  | waiting for start
    // ST_READ  | issuing addresses 0..DEPTH-1 to all banks
    // ST_DRAIN | flushing BRAM latency and lane skew stages
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Words per bank when an m x m matrix is striped across n banks.
    function automatic int bank_depth(input int m, input int n);
        return (m * m) / n;
    endfunction

    // Address width for a bank of the given depth; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_read_if.sv
// Handshake and BRAM-side bus of the mem_read sequencer.
// master: the environment (drives start and BRAM read data)
// slave : the mem_read sequencer
interface mem_read_if #(
    parameter int D_W = 8,
    parameter int N   = 3,
    parameter int AW  = 4
);
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [N-1:0]           rd_en_bram;
    logic [N-1:0][AW-1:0]   rd_addr_bram;
    logic [N-1:0][D_W-1:0]  rd_data_bram;
    logic [N-1:0]           out_valid;
    logic [N-1:0][D_W-1:0]  out_data;

    modport master (
        output start, rd_data_bram,
        input  busy, done, rd_en_bram, rd_addr_bram, out_valid, out_data
    );

    modport slave (
        input  start, rd_data_bram,
        output busy, done, rd_en_bram, rd_addr_bram, out_valid, out_data
    );
endinterface

// File: rtl/mem_read_lane_delay.sv
// lane_delay: DLY-stage valid/data delay line for one output lane.
// DLY = 0 is a combinational pass-through. Data is zeroed whenever valid is low,
// so the output data is 0 whenever the output valid is 0.
module lane_delay #(
    parameter int D_W = 8,
    parameter int DLY = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    input  logic [D_W-1:0] i_data,
    output logic           o_valid,
    output logic [D_W-1:0] o_data
);
    logic [D_W-1:0] w_data_m;

    assign w_data_m = i_valid ? i_data : '0;

    generate
        if (DLY == 0) begin : g_pass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = &{1'b0, clk, rst};
            assign o_valid = i_valid;
            assign o_data  = w_data_m;
        end else begin : g_dly
            logic [DLY-1:0]          r_valid;
            logic [DLY-1:0][D_W-1:0] r_data;

            // Shift valid and masked data one stage per clock.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid <= '0;
                    r_data  <= '0;
                end else begin
                    r_valid[0] <= i_valid;
                    r_data[0]  <= w_data_m;
                    for (int i = 1; i < DLY; i++) begin
                        r_valid[i] <= r_valid[i-1];
                        r_data[i]  <= r_data[i-1];
                    end
                end
            end

            assign o_valid = r_valid[DLY-1];
            assign o_data  = r_data[DLY-1];
        end
    endgenerate
endmodule

// File: rtl/mem_read.sv
// mem_read: reads DEPTH words from each of N BRAM banks in lockstep and presents
// them on N output lanes. Optional macro MEM_READ_SKEW_EN: lane x is skewed by x
// extra cycles (systolic feed) and DRAIN lasts N cycles; otherwise all lanes are
// aligned and DRAIN lasts one cycle.
//
// state    | meaning
// ST_IDLE  | waiting for start; done pulses here for one cycle after a pass
// ST_READ  | rd_en high on all banks, address 0..DEPTH-1 on consecutive cycles
// ST_DRAIN | rd_en low, address 0, last words ripple out of the lanes
module mem_read
    import sysarr_pkg::*;
#(
    parameter int D_W = 8,
    parameter int N   = 3,
    parameter int M   = 6
) (
    input  logic     clk,
    input  logic     rst,
    mem_read_if.slave bus
);
    localparam int DEPTH = bank_depth(M, N);
    localparam int AW    = addr_width(DEPTH);
`ifdef MEM_READ_SKEW_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif
    localparam int DRAIN_LEN = (SKEW != 0) ? N : 1;
    localparam int DCW       = $clog2(DRAIN_LEN) + 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_addr;
    logic [DCW-1:0]  r_drain_cnt;
    logic            r_done;
    logic [N-1:0]    r_rd_en_d1;
    logic            w_addr_last;
    logic            w_drain_tc;
    logic            w_reading;

    assign w_addr_last = (r_addr == AW'(DEPTH - 1));
    assign w_drain_tc  = (r_drain_cnt == '0);
    assign w_reading   = (r_state == ST_READ);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start)  w_state_nxt = ST_READ;
            ST_READ:  if (w_addr_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_tc)  w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // Address counter: counts during READ, back to 0 at the end of a pass and outside READ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_addr <= '0;
        else if (w_reading) r_addr <= w_addr_last ? '0 : r_addr + 1'b1;
        else                r_addr <= '0;
    end

    // Drain down-counter: loaded while reading, terminal count ends DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                      r_drain_cnt <= '0;
        else if (w_reading)                            r_drain_cnt <= DCW'(DRAIN_LEN - 1);
        else if (r_state == ST_DRAIN && !w_drain_tc)   r_drain_cnt <= r_drain_cnt - 1'b1;
    end

    // done pulses in the cycle after the last DRAIN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_done <= 1'b0;
        else      r_done <= (r_state == ST_DRAIN) && w_drain_tc;
    end

    // Read enable delayed by the BRAM latency marks valid read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rd_en_d1 <= '0;
        else      r_rd_en_d1 <= bus.rd_en_bram;
    end

    assign bus.rd_en_bram   = {N{w_reading}};
    assign bus.rd_addr_bram = w_reading ? {N{r_addr}} : '0;
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.done         = r_done;

    generate
        for (genvar x = 0; x < N; x++) begin : g_lane
            lane_delay #(
                .D_W (D_W),
                .DLY (x * SKEW)
            ) u_lane_delay (
                .clk     (clk),
                .rst     (rst),
                .i_valid (r_rd_en_d1[x]),
                .i_data  (bus.rd_data_bram[x]),
                .o_valid (bus.out_valid[x]),
                .o_data  (bus.out_data[x])
            );
        end
    endgenerate
endmodule

// File: doc/mem_read.md
MEM_READ -- requirements
Module: mem_read

Interface
REQ-001 SHALL have parameter D_W, default 8, data width per lane.
REQ-002 SHALL have parameter N, default 3, number of lanes / BRAM banks.
REQ-003 SHALL have parameter M, default 6, matrix dimension; per-bank depth DEPTH = (M*M)/N, address width AW = $clog2(DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  pulse requesting one full read pass.
REQ-007 SHALL have port busy  output  1  high while a pass is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse at end of pass.
REQ-009 SHALL have port rd_en_bram  output  [N-1:0]  per-bank read enable.
REQ-010 SHALL have port rd_addr_bram  output  [AW-1:0] x N  per-bank read address.
REQ-011 SHALL have port rd_data_bram  input  [D_W-1:0] x N  per-bank read data, valid one cycle after rd_en.
REQ-012 SHALL have port out_valid  output  [N-1:0]  per-lane output valid.
REQ-013 SHALL have port out_data  output  [D_W-1:0] x N  per-lane output data.

Function
REQ-014 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-015 In IDLE, start=1 SHALL move to READ next cycle; start SHALL be ignored outside IDLE.
REQ-016 In READ, all N rd_en_bram bits SHALL be high and rd_addr_bram[x] SHALL be 0,1,...,DEPTH-1 on consecutive cycles, identical across banks.
REQ-017 After address DEPTH-1 is issued, SHALL enter DRAIN with rd_en_bram=0 and addresses held at 0.
REQ-018 Lane x out_valid/out_data SHALL equal bank x read data delayed by 1 (BRAM latency) + x cycles (skew).
REQ-019 DRAIN SHALL last 1+(N-1) cycles, so the final word of lane N-1 is output on the last DRAIN cycle.
REQ-020 done SHALL pulse for one cycle on the cycle after DRAIN ends; busy SHALL be high in READ and DRAIN and low in the done cycle.
REQ-021 Address counter SHALL not wrap within a pass; it SHALL return to 0 for the next pass.
REQ-022 start asserted in the same cycle as done SHALL be accepted (FSM is in IDLE that cycle).
REQ-023 out_data SHALL be 0 whenever the corresponding out_valid is 0.

Reset
REQ-024 rst=0 SHALL immediately force IDLE, busy=0, done=0, rd_en_bram=0, rd_addr_bram=0, out_valid=0, out_data=0, and clear all skew stages.
REQ-025 Reset mid-pass SHALL abort the pass with no done pulse; the next start after reset release SHALL begin at address 0.

Configuration
REQ-026 Macro MEM_READ_SKEW_EN defined: per-lane skew of x cycles per REQ-018/019.
REQ-027 MEM_READ_SKEW_EN undefined: all lanes SHALL be aligned (latency 1 for every lane) and DRAIN SHALL last exactly 1 cycle.

Structure
REQ-028 A shared package sysarr_pkg SHALL hold the FSM state enum and a DEPTH/AW helper function, shared with mem_write.
REQ-029 Skew SHALL be a sub-module lane_delay (params D_W, DLY; DLY=0 allowed, pass-through) instantiated once per lane.

Verification (N=3, M=6, DEPTH=12, AW=4, skew enabled; start at cycle 0)
REQ-030 Single pass: bank x holds 16*x+addr -> rd_en high cycles 1-12; lane 0 valid cycles 2-13 with data 0..11; lane 2 valid cycles 4-15 with data 32..43; done at cycle 16.
REQ-031 Start while busy: extra start pulses at cycles 5 and 10 -> no effect; exactly one done, at cycle 16.
REQ-032 Back-to-back: start held high through cycle 16 -> second pass READ begins cycle 17, addresses restart at 0.
REQ-033 Reset mid-pass: rst=0 at cycle 7 -> all outputs 0 in that cycle, no done; new start after release -> full 12-word pass from address 0.
REQ-034 Skew disabled build: same stimulus as REQ-030 -> all three lanes valid cycles 2-13; done at cycle 14.
REQ-035 Idle check: no start for 50 cycles -> rd_en_bram, out_valid, busy and done stay 0.
